// File: rtl/imem_responder_if.sv
// Fetch-side request/response channels of the instruction memory responder.
// The fetch unit is the master; the responder is the slave.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [63:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency read pipeline feeding an in-order
// response FIFO, with credit-limited acceptance, flush and a word load port.
module imem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 4,
  parameter              INIT_FILE = ""
) (
  input  logic                     clock,
  input  logic                     reset,
  imem_responder_if.slave          fetch,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     busy
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] MAX_OUT  = CW'(QDEPTH);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic [63:0] addr;
    logic        err;
  } entry_t;

  logic [31:0]   r_mem [DEPTH];
  entry_t        r_pipe [LATENCY];
  logic [LATENCY-1:0] r_pv;
  entry_t        r_fifo [QDEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;

  logic          w_err;
  logic [IW-1:0] w_idx;
  entry_t        w_new;
  entry_t        w_head;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_rsp_valid;

  always_ff @(posedge clock) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  assign w_idx = fetch.req_addr[IW+1:2];
  assign w_err = (fetch.req_addr[1:0] != 2'b00) || (fetch.req_addr[63:IW+2] != '0);

  always_comb begin
    w_new.data = w_err ? NOP : r_mem[w_idx];
    w_new.addr = fetch.req_addr;
    w_new.err  = w_err;
  end

  assign fetch.req_ready = !reset && !ld_en && !flush && (r_out < MAX_OUT);
  assign w_accept    = fetch.req_valid && fetch.req_ready;
  assign w_rsp_valid = (r_cnt != '0);
  assign w_pop       = w_rsp_valid && fetch.rsp_ready;
  // The last pipeline stage drains into the FIFO unconditionally; the credit
  // limit on acceptance is what keeps the FIFO from overflowing.
  assign w_push      = r_pv[LATENCY-1] && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv  <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_out <= '0;
    end else if (flush) begin
      r_pv  <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_out <= '0;
    end else begin
      r_pv[0] <= w_accept;
      for (int unsigned i = 1; i < LATENCY; i++) r_pv[i] <= r_pv[i-1];
      if (w_push) r_wr <= (r_wr == LAST_PTR) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == LAST_PTR) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_out <= r_out + CW'(w_accept) - CW'(w_pop);
    end
  end

  // Payload registers carry no reset; the valid bits above qualify them.
  always_ff @(posedge clock) begin
    r_pipe[0] <= w_new;
    for (int unsigned i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    if (w_push) r_fifo[r_wr] <= r_pipe[LATENCY-1];
  end

  assign w_head          = r_fifo[r_rd];
  assign fetch.rsp_valid = w_rsp_valid;
  assign fetch.rsp_data  = w_rsp_valid ? w_head.data : '0;
  assign fetch.rsp_addr  = w_rsp_valid ? w_head.addr : '0;
  assign fetch.rsp_err   = w_rsp_valid ? w_head.err  : 1'b0;
  assign busy            = (r_out != '0);
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the responder's observable behaviour.
module tb_imem_responder;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned QDEPTH  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        busy;

  imem_responder_if fetch_if ();

  imem_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH), .INIT_FILE("")
  ) dut (
    .clock(clock), .reset(reset), .fetch(fetch_if), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within bound, expected one (t=%0t)", nm, $time);
  endtask

  // Model: words in memory, plus in-order list of pending responses, each
  // becoming visible LATENCY edges after its accept edge.
  typedef struct {
    logic [31:0]     d;
    logic [63:0]     a;
    logic            e;
    longint unsigned rdy;
  } exp_t;

  logic [31:0]     mem_m [DEPTH];
  exp_t            q [$];
  longint unsigned cyc = 0;
  bit              m_valid, m_ready, m_acc, m_pop;
  exp_t            m_new;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
    end else begin
      m_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      m_pop   = m_valid && fetch_if.rsp_ready;
      m_ready = !ld_en && !flush && (q.size() < QDEPTH);
      m_acc   = fetch_if.req_valid && m_ready;
      if (m_pop) void'(q.pop_front());
      if (flush) q.delete();
      if (m_acc) begin
        m_new.a   = fetch_if.req_addr;
        m_new.e   = (fetch_if.req_addr % 4 != 0) || (fetch_if.req_addr >= 4 * DEPTH);
        m_new.d   = m_new.e ? 32'h13 : mem_m[int'(fetch_if.req_addr / 4)];
        m_new.rdy = cyc + 1 + LATENCY;
        q.push_back(m_new);
      end
      if (ld_en) mem_m[ld_addr] = ld_data;
    end
    cyc++;
  end

  bit e_valid;
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_req_ready", fetch_if.req_ready, 0);
      chk("rst_rsp_valid", fetch_if.rsp_valid, 0);
      chk("rst_rsp_data",  fetch_if.rsp_data, 0);
      chk("rst_rsp_addr",  fetch_if.rsp_addr, 0);
      chk("rst_rsp_err",   fetch_if.rsp_err, 0);
      chk("rst_busy",      busy, 0);
    end else begin
      e_valid = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("req_ready", fetch_if.req_ready, !ld_en && !flush && (q.size() < QDEPTH));
      chk("rsp_valid", fetch_if.rsp_valid, e_valid);
      chk("busy", busy, q.size() != 0);
      if (e_valid) begin
        chk("rsp_data", fetch_if.rsp_data, q[0].d);
        chk("rsp_addr", fetch_if.rsp_addr, q[0].a);
        chk("rsp_err",  fetch_if.rsp_err,  q[0].e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [63:0] a);
    fetch_if.req_valid = 1'b1;
    fetch_if.req_addr  = a;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (fetch_if.req_ready) begin
        step();
        fetch_if.req_valid = 1'b0;
        return;
      end
    end
    fetch_if.req_valid = 1'b0;
    timeout("issue");
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (fetch_if.rsp_valid) begin
        ok = 1'b1;
        return;
      end
    end
    timeout("wait_rsp");
  endtask

  task automatic req_and_check(input string nm, input logic [63:0] a,
                               input logic [31:0] d, input logic e);
    bit ok;
    fetch_if.rsp_ready = 1'b1;
    issue(a);
    wait_rsp(ok);
    if (ok) begin
      chk({nm, "_data"}, fetch_if.rsp_data, d);
      chk({nm, "_err"},  fetch_if.rsp_err, e);
      chk({nm, "_addr"}, fetch_if.rsp_addr, a);
    end
    step();
  endtask

  int          cnt;
  logic [63:0] addr;
  bit          acc, ok;

  initial begin
    reset = 1'b1; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    fetch_if.req_valid = 1'b0; fetch_if.req_addr = '0; fetch_if.rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // Preload every word so all reads are defined; words 0..4 get known values.
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i);
      ld_data = (i < 4) ? 32'hA000_0000 + 32'(i) : (i == 4) ? 32'hC4C4_0004 : $urandom;
      step();
    end
    ld_en = 1'b0;

    // T1: four back-to-back fetches, first response two edges after first accept.
    fetch_if.rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fetch_if.req_valid = (i < 4);
      fetch_if.req_addr  = 64'(4 * i);
      @(negedge clock);
      if (i >= 3) begin
        chk("t1_valid", fetch_if.rsp_valid, 1);
        chk("t1_data",  fetch_if.rsp_data, 32'hA000_0000 + 32'(i - 3));
        chk("t1_addr",  fetch_if.rsp_addr, 64'(4 * (i - 3)));
      end else begin
        chk("t1_early_valid", fetch_if.rsp_valid, 0);
      end
      step();
    end
    fetch_if.req_valid = 1'b0;
    step();

    // T2: credit limit under back-pressure, then drain.
    fetch_if.rsp_ready = 1'b0;
    fetch_if.req_valid = 1'b1;
    addr = 64'd16;
    cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      fetch_if.req_addr = addr;
      @(negedge clock);
      acc = fetch_if.req_valid && fetch_if.req_ready;
      if (acc) cnt++;
      step();
      if (acc) addr += 4;
    end
    chk("t2_accepts", cnt, QDEPTH);
    @(negedge clock);
    chk("t2_ready_low", fetch_if.req_ready, 0);
    step();
    fetch_if.req_valid = 1'b0;
    fetch_if.rsp_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (fetch_if.rsp_valid && fetch_if.rsp_ready) cnt++;
      step();
    end
    chk("t2_pops", cnt, QDEPTH);

    // T3: misaligned and out-of-range requests return a flagged NOP.
    req_and_check("t3_misaligned", 64'd6, 32'h13, 1'b1);
    req_and_check("t3_range", 64'd1024, 32'h13, 1'b1);
    req_and_check("t3_good", 64'd8, 32'hA000_0002, 1'b0);

    // T4: flush with three outstanding.
    fetch_if.rsp_ready = 1'b0;
    issue(64'd0); issue(64'd4); issue(64'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clock);
    chk("t4_valid", fetch_if.rsp_valid, 0);
    chk("t4_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t4_quiet", fetch_if.rsp_valid, 0);
    end
    step();
    req_and_check("t4_after", 64'd0, 32'hA000_0000, 1'b0);

    // T5: load after accept does not alter the in-flight word; load blocks accept.
    fetch_if.rsp_ready = 1'b0;
    issue(64'd16);
    ld_en = 1'b1; ld_addr = 8'd4; ld_data = 32'hBBBB_0004;
    fetch_if.req_valid = 1'b1; fetch_if.req_addr = 64'd20;
    @(negedge clock);
    chk("t5_ready_low", fetch_if.req_ready, 0);
    step();
    ld_en = 1'b0; fetch_if.req_valid = 1'b0;
    fetch_if.rsp_ready = 1'b1;
    wait_rsp(ok);
    if (ok) chk("t5_old_word", fetch_if.rsp_data, 32'hC4C4_0004);
    step();
    req_and_check("t5_new_word", 64'd16, 32'hBBBB_0004, 1'b0);

    // T6: reset mid-flight clears outputs at once; memory survives.
    fetch_if.rsp_ready = 1'b0;
    issue(64'd0); issue(64'd4);
    chk("t6_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_rsp_valid", fetch_if.rsp_valid, 0);
    chk("t6_req_ready", fetch_if.req_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_data", fetch_if.rsp_data, 0);
    step(); step();
    reset = 1'b0;
    req_and_check("t6_after", 64'd0, 32'hA000_0000, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      flush   = ($urandom_range(0, 49) == 0);
      ld_en   = ($urandom_range(0, 19) == 0);
      ld_addr = 8'($urandom_range(0, 255));
      ld_data = $urandom;
      fetch_if.req_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        8:       fetch_if.req_addr = 64'({$urandom_range(0, 255), 2'b00}) | 64'($urandom_range(1, 3));
        9:       fetch_if.req_addr = {$urandom, $urandom};
        default: fetch_if.req_addr = 64'({$urandom_range(0, 255), 2'b00});
      endcase
      fetch_if.rsp_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    flush = 1'b0; ld_en = 1'b0; fetch_if.req_valid = 1'b0; fetch_if.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    @(negedge clock);
    chk("drain_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
